// File: rtl/special_cases_pipe_if.sv
// special_cases_pipe_if: operand/result handshake bundle for special_cases_pipe.
// Sticky flag signals exist only when SPC_STICKY_FLAGS_EN is defined.
interface special_cases_pipe_if #(
    parameter int size_exception_field = 2,
    parameter int TAG_WIDTH = 4
);
    logic                            valid_i;
    logic                            ready_o;
    logic [1:0]                      op_i;
    logic [size_exception_field-1:0] sp_case_a_i;
    logic [size_exception_field-1:0] sp_case_b_i;
    logic                            sign_a_i;
    logic                            sign_b_i;
    logic [TAG_WIDTH-1:0]            tag_i;
    logic                            valid_o;
    logic                            ready_i;
    logic [size_exception_field-1:0] sp_case_o;
    logic                            sign_o;
    logic                            invalid_o;
    logic                            div_zero_o;
    logic [TAG_WIDTH-1:0]            tag_o;
`ifdef SPC_STICKY_FLAGS_EN
    logic                            clear_sticky_i;
    logic                            sticky_invalid_o;
    logic                            sticky_div_zero_o;
`endif
    modport slave (
        input  valid_i, op_i, sp_case_a_i, sp_case_b_i, sign_a_i, sign_b_i, tag_i, ready_i,
        output ready_o, valid_o, sp_case_o, sign_o, invalid_o, div_zero_o, tag_o
`ifdef SPC_STICKY_FLAGS_EN
        , input clear_sticky_i
        , output sticky_invalid_o, sticky_div_zero_o
`endif
    );
    modport master (
        output valid_i, op_i, sp_case_a_i, sp_case_b_i, sign_a_i, sign_b_i, tag_i, ready_i,
        input  ready_o, valid_o, sp_case_o, sign_o, invalid_o, div_zero_o, tag_o
`ifdef SPC_STICKY_FLAGS_EN
        , output clear_sticky_i
        , input sticky_invalid_o, sticky_div_zero_o
`endif
    );
endinterface

// File: rtl/special_cases_pipe.sv
// special_cases_pipe: pipelined exception-class decoder for MUL/DIV/ADD/SUB with tag passthrough.
// Optional sticky invalid/div-zero flags via SPC_STICKY_FLAGS_EN.
module special_cases_pipe #(
    parameter int size_exception_field = 2,
    parameter logic [size_exception_field-1:0] zero = 0,
    parameter logic [size_exception_field-1:0] normal_number = 1,
    parameter logic [size_exception_field-1:0] infinity = 2,
    parameter logic [size_exception_field-1:0] NaN = 3,
    parameter int LATENCY = 2,
    parameter int TAG_WIDTH = 4
) (
    input logic clk_i,
    input logic rst_n_i,
    special_cases_pipe_if.slave bus
);
    typedef struct packed {
        logic                            v;
        logic [size_exception_field-1:0] cls;
        logic                            sgn;
        logic                            inv;
        logic                            dz;
        logic [TAG_WIDTH-1:0]            tag;
    } stage_t;

    stage_t pipe [LATENCY];
    stage_t in_s;
    stage_t last;
    logic adv, accept, sa, sb, eb, is_div;
    logic [size_exception_field-1:0] a, b;

    assign adv = ~bus.valid_o | bus.ready_i;
    assign bus.ready_o = adv;
    assign accept = bus.valid_i & adv;
    assign a = bus.sp_case_a_i;
    assign b = bus.sp_case_b_i;
    assign sa = bus.sign_a_i;
    assign sb = bus.sign_b_i;
    assign eb = bus.sign_b_i ^ bus.op_i[0];
    assign is_div = bus.op_i == 2'd1;

    always_comb begin
        in_s = '0;
        in_s.v = accept;
        in_s.tag = bus.tag_i;
        in_s.cls = zero;
        if (a == NaN || b == NaN) begin
            in_s.cls = NaN;
        end else if (!bus.op_i[1] && is_div) begin
            in_s.sgn = sa ^ sb;
            if (a == b && a != normal_number) begin
                in_s.cls = NaN;
                in_s.inv = 1'b1;
            end else if (a == zero || b == infinity) begin
                in_s.cls = zero;
            end else if (b == zero || a == infinity) begin
                in_s.cls = infinity;
                in_s.dz = a == normal_number;
            end else begin
                in_s.cls = normal_number;
            end
        end else if (!bus.op_i[1]) begin
            in_s.sgn = sa ^ sb;
            if ((a == zero && b == infinity) || (a == infinity && b == zero)) begin
                in_s.cls = NaN;
                in_s.inv = 1'b1;
            end else if (a == zero || b == zero) begin
                in_s.cls = zero;
            end else begin
                in_s.cls = (a == infinity || b == infinity) ? infinity : normal_number;
            end
        end else if (a == infinity && b == infinity) begin
            // Opposite-signed infinities cancel into an invalid NaN.
            in_s.cls = (sa == eb) ? infinity : NaN;
            in_s.inv = sa != eb;
            in_s.sgn = sa & (sa == eb);
        end else if (a == infinity || b == infinity) begin
            in_s.cls = infinity;
            in_s.sgn = (a == infinity) ? sa : eb;
        end else if (a == zero && b == zero) begin
            in_s.sgn = sa & eb;
        end else begin
            in_s.cls = normal_number;
            in_s.sgn = (a == zero) ? eb : (b == zero) ? sa : 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
                pipe[i].cls <= zero;
            end
        end else if (adv) begin
            pipe[0] <= in_s;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign last = pipe[LATENCY-1];
    assign bus.valid_o = last.v;
    assign bus.sp_case_o = last.cls;
    assign bus.sign_o = last.sgn;
    assign bus.invalid_o = last.inv;
    assign bus.div_zero_o = last.dz;
    assign bus.tag_o = last.tag;

`ifdef SPC_STICKY_FLAGS_EN
    logic hs, st_inv, st_dz;
    assign hs = bus.valid_o & bus.ready_i;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_inv <= 1'b0;
            st_dz <= 1'b0;
        end else begin
            st_inv <= (hs & bus.invalid_o) | (st_inv & ~bus.clear_sticky_i);
            st_dz <= (hs & bus.div_zero_o) | (st_dz & ~bus.clear_sticky_i);
        end
    end
    assign bus.sticky_invalid_o = st_inv;
    assign bus.sticky_div_zero_o = st_dz;
`else
    // Without sticky state, flags are reported per result only.
`endif
endmodule

// File: tb/tb_special_cases_pipe.sv
// tb_special_cases_pipe: vector table, directed stall/reset sequences and randomized scoreboard run.
module tb_special_cases_pipe;
    localparam int LAT = 2;
    localparam logic [1:0] Z = 2'd0, N = 2'd1, I = 2'd2, Q = 2'd3;
    localparam logic [1:0] MUL = 2'd0, DIV = 2'd1, ADD = 2'd2, SUB = 2'd3;

    typedef struct packed {
        logic [1:0] cls;
        logic       sgn;
        logic       inv;
        logic       dz;
        logic [3:0] tag;
    } exp_t;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] a;
        logic [1:0] b;
        logic       sa;
        logic       sb;
        logic [3:0] tag;
        exp_t       e;
    } vec_t;

    logic clk = 0, rst_n = 0;
    int checks = 0, errors = 0;
    exp_t q[$];

    special_cases_pipe_if bus();
    special_cases_pipe #(.LATENCY(LAT)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t cur();
        return '{bus.sp_case_o, bus.sign_o, bus.invalid_o, bus.div_zero_o, bus.tag_o};
    endfunction

    function automatic int rank(input logic [1:0] c);
        return (c == Z) ? 0 : (c == N) ? 1 : 2;
    endfunction

    // Division is modelled as multiplication by the reciprocal class; addition by magnitude dominance.
    function automatic exp_t model(input logic [1:0] op, a, b, input logic sa, sb, input logic [3:0] tag);
        exp_t r;
        logic [1:0] bb;
        logic eb;
        r = '{Z, 1'b0, 1'b0, 1'b0, tag};
        if (a == Q || b == Q) begin
            r.cls = Q;
        end else if (op == MUL || op == DIV) begin
            bb = (op == DIV) ? ((b == Z) ? I : (b == I) ? Z : N) : b;
            r.sgn = sa ^ sb;
            if ((a == Z && bb == I) || (a == I && bb == Z)) begin
                r.cls = Q;
                r.inv = 1;
            end else if (a == Z || bb == Z) begin
                r.cls = Z;
            end else if (a == I || bb == I) begin
                r.cls = I;
                r.dz = (op == DIV) && a == N && b == Z;
            end else begin
                r.cls = N;
            end
        end else begin
            eb = sb ^ (op == SUB);
            if (a == I && b == I) begin
                r.cls = (sa == eb) ? I : Q;
                r.inv = (sa != eb);
                r.sgn = (sa == eb) ? sa : 1'b0;
            end else if (rank(a) > rank(b)) begin
                r.cls = a;
                r.sgn = sa;
            end else if (rank(b) > rank(a)) begin
                r.cls = b;
                r.sgn = eb;
            end else begin
                r.cls = a;
                r.sgn = (a == Z) ? (sa & eb) : 1'b0;
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [1:0] op, a, b, input logic sa, sb, input logic [3:0] tag);
        bus.valid_i = 1;
        bus.op_i = op;
        bus.sp_case_a_i = a;
        bus.sp_case_b_i = b;
        bus.sign_a_i = sa;
        bus.sign_b_i = sb;
        bus.tag_i = tag;
    endtask

    task automatic wait_valid(input string name);
        int w = 0;
        while (!bus.valid_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(name, bus.valid_o, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string n;
        n = $sformatf("vec%0d", idx);
        drive(v.op, v.a, v.b, v.sa, v.sb, v.tag);
        #1 chk({n, "_ready"}, bus.ready_o, 1);
        @(negedge clk);
        bus.valid_i = 0;
        for (int k = 1; k < LAT; k++) begin
            chk({n, "_early"}, bus.valid_o, 0);
            @(negedge clk);
        end
        chk({n, "_valid"}, bus.valid_o, 1);
        chk({n, "_cls"}, bus.sp_case_o, v.e.cls);
        chk({n, "_sign"}, bus.sign_o, v.e.sgn);
        chk({n, "_inv"}, bus.invalid_o, v.e.inv);
        chk({n, "_dz"}, bus.div_zero_o, v.e.dz);
        chk({n, "_tag"}, bus.tag_o, v.e.tag);
        @(negedge clk);
    endtask

    task automatic rand_cycle(input bit gen);
        exp_t e;
        if (gen) begin
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            bus.valid_i = $urandom_range(0, 2) != 0;
            bus.ready_i = $urandom_range(0, 3) != 0;
        end
        #1;
        if (bus.valid_o && bus.ready_i) begin
            if (q.size() == 0) chk("rand_spurious", 1, 0);
            else begin
                e = q.pop_front();
                chk("rand_out", cur(), e);
            end
        end
        if (bus.valid_i && bus.ready_o)
            q.push_back(model(bus.op_i, bus.sp_case_a_i, bus.sp_case_b_i, bus.sign_a_i, bus.sign_b_i, bus.tag_i));
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{DIV, N, Z, 1'b0, 1'b1, 4'd5,  '{I, 1'b1, 1'b0, 1'b1, 4'd5}};
        vecs[1]  = '{MUL, Z, I, 1'b0, 1'b0, 4'd1,  '{Q, 1'b0, 1'b1, 1'b0, 4'd1}};
        vecs[2]  = '{MUL, Q, I, 1'b1, 1'b0, 4'd2,  '{Q, 1'b0, 1'b0, 1'b0, 4'd2}};
        vecs[3]  = '{SUB, I, I, 1'b0, 1'b0, 4'd3,  '{Q, 1'b0, 1'b1, 1'b0, 4'd3}};
        vecs[4]  = '{ADD, I, I, 1'b0, 1'b0, 4'd4,  '{I, 1'b0, 1'b0, 1'b0, 4'd4}};
        vecs[5]  = '{ADD, Z, Z, 1'b1, 1'b1, 4'd6,  '{Z, 1'b1, 1'b0, 1'b0, 4'd6}};
        vecs[6]  = '{DIV, I, Z, 1'b1, 1'b0, 4'd7,  '{I, 1'b1, 1'b0, 1'b0, 4'd7}};
        vecs[7]  = '{DIV, Z, Z, 1'b0, 1'b0, 4'd8,  '{Q, 1'b0, 1'b1, 1'b0, 4'd8}};
        vecs[8]  = '{ADD, N, Z, 1'b1, 1'b0, 4'd9,  '{N, 1'b1, 1'b0, 1'b0, 4'd9}};
        vecs[9]  = '{SUB, Z, N, 1'b0, 1'b0, 4'd10, '{N, 1'b1, 1'b0, 1'b0, 4'd10}};
        vecs[10] = '{ADD, I, N, 1'b1, 1'b0, 4'd11, '{I, 1'b1, 1'b0, 1'b0, 4'd11}};
        vecs[11] = '{MUL, N, N, 1'b1, 1'b1, 4'd12, '{N, 1'b0, 1'b0, 1'b0, 4'd12}};
        vecs[12] = '{DIV, N, I, 1'b0, 1'b1, 4'd13, '{Z, 1'b1, 1'b0, 1'b0, 4'd13}};

        drive(MUL, Z, Z, 0, 0, 0);
        bus.valid_i = 0;
        bus.ready_i = 1;
`ifdef SPC_STICKY_FLAGS_EN
        bus.clear_sticky_i = 0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_outs", cur(), '0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_idle", bus.valid_o, 0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Stall with four ops in flight, then release and collect in order.
        fork
            begin
                for (int t = 0; t < 4; t++) begin
                    int w = 0;
                    drive(DIV, N, Z, 0, 1, 4'(t));
                    #1;
                    while (!bus.ready_o && w < 50) begin
                        @(negedge clk);
                        #1 w++;
                    end
                    @(negedge clk);
                end
                bus.valid_i = 0;
            end
            begin
                wait_valid("stall_first");
                bus.ready_i = 0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", bus.ready_o, 0);
                    chk("stall_valid", bus.valid_o, 1);
                    chk("stall_tag", bus.tag_o, 0);
                    chk("stall_cls", bus.sp_case_o, I);
                end
                bus.ready_i = 1;
                for (int k = 0; k < 4; k++) begin
                    wait_valid("drain_valid");
                    chk("drain_tag", bus.tag_o, k);
                    @(negedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("after_drain_idle", bus.valid_o, 0);

        // Asynchronous reset with two results in flight.
        drive(DIV, N, Z, 1, 0, 4'd9);
        @(negedge clk);
        drive(ADD, I, N, 1, 0, 4'd10);
        @(negedge clk);
        bus.valid_i = 0;
        chk("pre_rst_valid", bus.valid_o, 1);
        rst_n = 0;
        #1;
        chk("midrst_valid", bus.valid_o, 0);
        chk("midrst_outs", cur(), '0);
        @(negedge clk);
        rst_n = 1;
        begin
            int seen = 0;
            repeat (5) begin
                @(negedge clk);
                seen += int'(bus.valid_o);
            end
            chk("no_stale", seen, 0);
        end

`ifdef SPC_STICKY_FLAGS_EN
        chk("sticky_rst", {bus.sticky_invalid_o, bus.sticky_div_zero_o}, 0);
        drive(MUL, Z, I, 0, 0, 1);
        @(negedge clk);
        bus.valid_i = 0;
        wait_valid("sticky_v1");
        @(negedge clk);
        chk("sticky_inv_set", bus.sticky_invalid_o, 1);
        chk("sticky_dz_clr", bus.sticky_div_zero_o, 0);
        bus.clear_sticky_i = 1;
        @(negedge clk);
        bus.clear_sticky_i = 0;
        chk("sticky_inv_cleared", bus.sticky_invalid_o, 0);
        drive(DIV, I, I, 0, 0, 2);
        @(negedge clk);
        bus.valid_i = 0;
        wait_valid("sticky_v2");
        bus.clear_sticky_i = 1;
        @(negedge clk);
        bus.clear_sticky_i = 0;
        chk("sticky_set_wins", bus.sticky_invalid_o, 1);
        drive(DIV, N, Z, 0, 0, 3);
        @(negedge clk);
        bus.valid_i = 0;
        wait_valid("sticky_v3");
        @(negedge clk);
        chk("sticky_dz_set", bus.sticky_div_zero_o, 1);
        bus.clear_sticky_i = 1;
        @(negedge clk);
        bus.clear_sticky_i = 0;
        chk("sticky_both_cleared", {bus.sticky_invalid_o, bus.sticky_div_zero_o}, 0);
`endif

        // Randomized run against the reference model, with hold checking under backpressure.
        begin
            bit hold_pend = 0;
            exp_t held = '0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (hold_pend) chk("rand_hold", cur(), held);
                rand_cycle(1);
                hold_pend = bus.valid_o && !bus.ready_i;
                held = cur();
            end
            bus.valid_i = 0;
            bus.ready_i = 1;
            for (int c = 0; c < 20 && q.size() != 0; c++) begin
                @(negedge clk);
                rand_cycle(0);
            end
            chk("rand_queue_empty", q.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/special_cases_pipe.md
Name: special_cases_pipe

Overview:
- Pipelined, multi-operation successor to the combinational divider special-case decoder.
- Classifies the result exception class for MUL, DIV, ADD and SUB from the two operand exception fields and signs.
- Also produces result sign, invalid and divide-by-zero flags.
- Sits between operand unpack and the arithmetic datapath result mux; carries a tag so results realign with the mantissa pipeline.

Parameters:
size_exception_field, 2, width of exception class field
zero, 0, class code zero
normal_number, 1, class code normal
infinity, 2, class code infinity
NaN, 3, class code NaN
LATENCY, 2, pipeline stages, legal 1..4
TAG_WIDTH, 4, width of passthrough tag

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
valid_i  in  1  input operands valid
ready_o  out  1  block accepts input this cycle
op_i  in  2  0=MUL 1=DIV 2=ADD 3=SUB
sp_case_a_i  in  size_exception_field  class of operand A (dividend)
sp_case_b_i  in  size_exception_field  class of operand B (divisor)
sign_a_i  in  1  sign of A
sign_b_i  in  1  sign of B
tag_i  in  TAG_WIDTH  user tag
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
sp_case_o  out  size_exception_field  result class
sign_o  out  1  result sign
invalid_o  out  1  NaN generated from non-NaN operands
div_zero_o  out  1  finite nonzero divided by zero
tag_o  out  TAG_WIDTH  tag aligned with result

Behaviour:
- Decided: single clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset: all stage valids 0, valid_o=0, sp_case_o=zero, sign_o=0, invalid_o=0, div_zero_o=0, tag_o=0. ready_o=1 after reset.
- Reset mid-operation: all in-flight results discarded, no output.
- Classification is combinational on the input side and registered into stage 1. Stages 2..LATENCY are pure registers.
- Latency: a result appears LATENCY cycles after acceptance when there is no stall.
- Handshake:
  - advance = ~valid_o | ready_i; the whole pipeline shifts when advance=1, otherwise all stages hold.
  - ready_o = advance; accept = valid_i & ready_o.
  - A non-accepted slot inserts a bubble (valid=0).
  - Outputs hold stable while valid_o=1 and ready_i=0.
- NaN in either operand: result NaN, invalid=0, sign=0, for all ops.
- MUL:
  - sign = sign_a^sign_b.
  - zero*inf or inf*zero: NaN, invalid=1.
  - zero*{zero,normal}: zero.
  - inf*{normal,inf}: infinity.
  - normal*normal: normal.
- DIV:
  - sign = sign_a^sign_b.
  - 0/0: NaN, invalid=1. inf/inf: NaN, invalid=1.
  - 0/normal and 0/inf: zero. normal/inf: zero.
  - normal/0: infinity, div_zero=1. inf/0: infinity, div_zero=0. inf/normal: infinity.
  - normal/normal: normal.
- ADD/SUB: effective sign_b' = sign_b ^ (op==SUB).
  - inf+inf with equal signs: infinity, sign_a.
  - inf+inf with opposite signs: NaN, invalid=1.
  - inf+finite: infinity, sign of the inf operand.
  - zero+zero: zero, sign = sign_a & sign_b'.
  - zero+normal: normal, sign of the normal operand. normal+zero: normal, sign_a.
  - normal+normal: normal, sign=0 (datapath supplies the sign).
- Flags are mutually exclusive; both are 0 whenever the result is normal or zero.

Optional Feature:
- Macro SPC_STICKY_FLAGS_EN.
- Defined:
  - Adds input clear_sticky_i and outputs sticky_invalid_o and sticky_div_zero_o.
  - A sticky bit sets on any output handshake (valid_o & ready_i) carrying the corresponding flag.
  - clear_sticky_i clears both bits. If clear and set occur in the same cycle, set wins.
  - Reset value of both sticky bits is 0.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- LATENCY=2, ready_i=1, DIV, A=normal(1) B=zero(0), signs 0/1, tag=5 -> two cycles later: valid_o=1, sp_case_o=2, sign_o=1, div_zero_o=1, tag_o=5.
- MUL, A=zero, B=infinity -> sp_case_o=3, invalid_o=1; repeat with A=NaN -> sp_case_o=3, invalid_o=0.
- SUB, A=inf sign0, B=inf sign0 -> NaN, invalid=1; ADD with same operands -> infinity sign0; ADD zero sign1 + zero sign1 -> zero sign1.
- Back-to-back 4 ops with ready_i=0 from the cycle of the first valid_o -> ready_o=0, outputs frozen, no loss; release ready_i -> results emerge in order, tags 0,1,2,3.
- Assert rst_n_i low mid-stream with 2 results in flight -> immediately valid_o=0 and all outputs at reset values; no stale results after release.
- With SPC_STICKY_FLAGS_EN: invalid op then clear_sticky_i pulse -> sticky_invalid_o=1 then 0; clear coinciding with a flagged handshake -> stays 1.
